sr_latch_bank: RTL and testbench
================================

// Module: sr_latch_bank
// PURPOSE
//  - Clocked, parametrised bank of N set/reset latch channels for cell-level models that need deterministic, cycle-accurate SR storage.
//  - Replaces free-running SR cells where a synchronous-reset, race-aware version is required.
//  - Selectable input polarity (NAND- or NOR-style) and configurable both-asserted policy.
//  - Adds race detection, a sticky illegal-input flag and an output delay pipeline that models cell propagation in clock cycles.
// PARAMETERS
//  N          8    number of independent latch channels (1..32)
//  ACTIVE_LOW 1    1: s/r active-low (NAND style); 0: s/r active-high (NOR style)
//  INIT       '0   N-bit value of q per channel after reset
//  BOTH_MODE  0    both asserted: 0 = q=nq=1 (NAND); 1 = set wins; 2 = reset wins; 3 = hold
//  RACE_VAL   0    q value taken when both inputs release in the same cycle from the BOTH state (mode 0 only)
//  DELAY      1    output pipeline stages (0..4); 0 = outputs driven directly from the state register
// PORTS
//  clk            in   1  clock, all state on rising edge
//  reset          in   1  synchronous, active-high reset
//  s              in   N  per-channel set request (polarity per ACTIVE_LOW)
//  r              in   N  per-channel reset request (polarity per ACTIVE_LOW)
//  clr_sticky     in   1  clears illegal_sticky (all channels)
//  q              out  N  latch output
//  nq             out  N  complementary output; equals ~q except in the BOTH state
//  both_flag      out  N  channel in the BOTH state (pipelined with q)
//  race_pulse     out  N  one-cycle pulse on simultaneous release from BOTH (pipelined with q)
//  illegal_sticky out  N  set once s and r were both asserted; not pipelined
// BEHAVIOUR
//  - Input normalisation: S = ACTIVE_LOW ? ~s : s; R likewise. All logic below uses S/R (1 = asserted).
//  - Per-channel states: Q0 (q=0,nq=1), Q1 (q=1,nq=0), QB (q=1,nq=1). QB is reachable only when BOTH_MODE=0.
//  - Transitions, evaluated on each rising edge when reset=0:
//    - S&~R -> Q1.
//    - ~S&R -> Q0.
//    - ~S&~R: Q0/Q1 hold. From QB, go to RACE_VAL ? Q1 : Q0 and raise race for that cycle.
//    - S&R: mode 0 -> QB; mode 1 -> Q1; mode 2 -> Q0; mode 3 -> hold the current state.
//  - Leaving QB with only one input released is not a race: ~S&R -> Q0 and S&~R -> Q1, no pulse.
//  - Latency: inputs sampled at edge k update state at edge k. q/nq/both_flag/race_pulse reflect that state DELAY edges later.
//    - DELAY=0: visible right after edge k.
//    - DELAY=n: visible after edge k+n.
//  - race_pulse is high for exactly one output cycle per race event.
//  - illegal_sticky[i]:
//    - set on the edge at which S[i]&R[i] is sampled, in every BOTH_MODE;
//    - cleared on the edge at which clr_sticky=1;
//    - if set and clear coincide, set wins.
//    - Updates at edge k with no pipeline.
//  - Reset (synchronous, reset=1 at an edge):
//    - state = INIT ? Q1 : Q0 per channel;
//    - every pipeline stage loaded with the INIT outputs, so q=INIT, nq=~INIT;
//    - both_flag=0, race_pulse=0, illegal_sticky=0.
//  - Reset mid-operation:
//    - discards in-flight pipeline contents, with no race_pulse emitted;
//    - inputs are ignored while reset=1;
//    - the first sample is taken at the first edge with reset=0.
//  - Reset has priority over clr_sticky and all inputs.
//  - Channels are fully independent; no cross-channel interaction.
//  - No X propagation: state is always one of Q0/Q1/QB. Out-of-range BOTH_MODE or DELAY is a static assertion failure.
// TESTING
//  1. Reset, INIT=8'hA5, DELAY=1: reset for 2 edges.
//     -> q=A5, nq=5A, flags 0, both during reset and one cycle after release.
//  2. ACTIVE_LOW=1, ch0: s=0,r=1 at edge 1.
//     -> q[0]=1 after edge 2 (DELAY=1). Then s=1,r=0 -> q[0]=0 one edge later.
//  3. BOTH_MODE=0, ch3: both asserted 3 cycles, then both released the same cycle.
//     -> q=nq=1 and both_flag=1 during hold; then q[3]=RACE_VAL, race_pulse[3] high 1 cycle; illegal_sticky[3]=1.
//  4. BOTH_MODE=0, ch3: from QB release s only.
//     -> Q0 (q=0,nq=1), race_pulse stays 0.
//  5. For modes 1/2/3, both asserted from Q0 and from Q1.
//     -> Q1 / Q0 / unchanged respectively; illegal_sticky set. clr_sticky together with a new S&R -> stays 1; clr_sticky alone -> 0.
//  6. DELAY=3: toggle ch7 every cycle, then assert reset while changes are in flight.
//     -> q follows with exactly 3-cycle lag; after reset, q=INIT immediately with no stale value or race_pulse.

Source files
------------

// File: rtl/sr_latch_bank_if.sv
// sr_latch_bank_if: request/response bundle for sr_latch_bank.
//   s, r         per-channel set/reset requests (polarity set by the bank)
//   clr_sticky   clears every illegal_sticky bit
//   q, nq        latch outputs
//   both_flag    channel sitting in the both-asserted state
//   race_pulse   one-cycle pulse on simultaneous release from the both state
//   illegal_sticky  remembers that s and r were asserted together
interface sr_latch_bank_if #(parameter int N = 8);
  logic [N-1:0] s;
  logic [N-1:0] r;
  logic         clr_sticky;
  logic [N-1:0] q;
  logic [N-1:0] nq;
  logic [N-1:0] both_flag;
  logic [N-1:0] race_pulse;
  logic [N-1:0] illegal_sticky;

  modport master (output s, r, clr_sticky,
                  input  q, nq, both_flag, race_pulse, illegal_sticky);
  modport slave  (input  s, r, clr_sticky,
                  output q, nq, both_flag, race_pulse, illegal_sticky);
endinterface

// File: rtl/sr_latch_bank.sv
// sr_latch_bank: N independent clocked SR latch channels.
//   clk    rising-edge clock for all state
//   reset  synchronous active-high reset, overrides every other input
//   bus    sr_latch_bank_if slave modport (s/r/clr_sticky in, flags out)
// Each channel holds Q0/Q1/QB, handles the both-asserted case per BOTH_MODE,
// flags simultaneous release from QB as a race, and delays q/nq/both/race
// by DELAY cycles. illegal_sticky is reported without delay.

// One channel. pipe[0] is the architectural state; pipe[1..DELAY] model
// propagation delay and carry the race bit alongside q/nq.
module sr_lane #(
  parameter int ACTIVE_LOW = 1,
  parameter bit INIT_BIT   = 1'b0,
  parameter int BOTH_MODE  = 0,
  parameter int RACE_VAL   = 0,
  parameter int DELAY      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic r,
  input  logic clr_sticky,
  output logic q,
  output logic nq,
  output logic both_flag,
  output logic race_pulse,
  output logic illegal_sticky
);
  typedef struct packed {
    logic q;
    logic nq;
    logic race;
  } cell_t;

  localparam cell_t C_Q0   = '{q: 1'b0, nq: 1'b1, race: 1'b0};
  localparam cell_t C_Q1   = '{q: 1'b1, nq: 1'b0, race: 1'b0};
  localparam cell_t C_QB   = '{q: 1'b1, nq: 1'b1, race: 1'b0};
  localparam cell_t C_INIT = INIT_BIT ? C_Q1 : C_Q0;
  // Landing state after a simultaneous release from QB, race bit raised.
  localparam cell_t C_RACE = (RACE_VAL != 0) ? '{q: 1'b1, nq: 1'b0, race: 1'b1}
                                             : '{q: 1'b0, nq: 1'b1, race: 1'b1};

  logic                s_n, r_n;
  cell_t               nxt;
  cell_t [DELAY:0]     pipe;
  logic                sticky;

  assign s_n = (ACTIVE_LOW != 0) ? ~s : s;
  assign r_n = (ACTIVE_LOW != 0) ? ~r : r;

  always_comb begin
    nxt      = pipe[0];
    nxt.race = 1'b0;
    case ({s_n, r_n})
      2'b10:   nxt = C_Q1;
      2'b01:   nxt = C_Q0;
      2'b00:   if (pipe[0].q && pipe[0].nq) nxt = C_RACE;
      default: begin
        case (BOTH_MODE)
          0:       nxt = C_QB;
          1:       nxt = C_Q1;
          2:       nxt = C_Q0;
          default: ;  // hold
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Flush the whole delay line so no stale value or race escapes.
      pipe   <= {(DELAY+1){C_INIT}};
      sticky <= 1'b0;
    end else begin
      pipe[0] <= nxt;
      for (int i = 1; i <= DELAY; i++) pipe[i] <= pipe[i-1];
      // Set beats clear when they land on the same edge.
      if (s_n && r_n)      sticky <= 1'b1;
      else if (clr_sticky) sticky <= 1'b0;
    end
  end

  assign q              = pipe[DELAY].q;
  assign nq             = pipe[DELAY].nq;
  assign both_flag      = pipe[DELAY].q & pipe[DELAY].nq;
  assign race_pulse     = pipe[DELAY].race;
  assign illegal_sticky = sticky;
endmodule

module sr_latch_bank #(
  parameter int           N          = 8,
  parameter int           ACTIVE_LOW = 1,
  parameter logic [N-1:0] INIT       = '0,
  parameter int           BOTH_MODE  = 0,
  parameter int           RACE_VAL   = 0,
  parameter int           DELAY      = 1
) (
  input  logic           clk,
  input  logic           reset,
  sr_latch_bank_if.slave bus
);
  if (N < 1 || N > 32) begin : g_bad_n
    $error("sr_latch_bank: N out of range 1..32");
  end
  if (BOTH_MODE < 0 || BOTH_MODE > 3) begin : g_bad_mode
    $error("sr_latch_bank: BOTH_MODE out of range 0..3");
  end
  if (DELAY < 0 || DELAY > 4) begin : g_bad_delay
    $error("sr_latch_bank: DELAY out of range 0..4");
  end

  logic [N-1:0] q_v, nq_v, both_v, race_v, ill_v;

  for (genvar i = 0; i < N; i++) begin : g_lane
    sr_lane #(
      .ACTIVE_LOW (ACTIVE_LOW),
      .INIT_BIT   (INIT[i]),
      .BOTH_MODE  (BOTH_MODE),
      .RACE_VAL   (RACE_VAL),
      .DELAY      (DELAY)
    ) u_lane (
      .clk            (clk),
      .reset          (reset),
      .s              (bus.s[i]),
      .r              (bus.r[i]),
      .clr_sticky     (bus.clr_sticky),
      .q              (q_v[i]),
      .nq             (nq_v[i]),
      .both_flag      (both_v[i]),
      .race_pulse     (race_v[i]),
      .illegal_sticky (ill_v[i])
    );
  end

  assign bus.q              = q_v;
  assign bus.nq             = nq_v;
  assign bus.both_flag      = both_v;
  assign bus.race_pulse     = race_v;
  assign bus.illegal_sticky = ill_v;
endmodule

// File: tb/tb_sr_latch_bank.sv
// Drives five differently-configured banks with the same logical S/R
// stream and compares every output against a behavioural model.
module tb_sr_latch_bank;
  localparam int NI = 5;
  localparam int           AL     [NI] = '{1, 0, 1, 0, 1};
  localparam int           MODE   [NI] = '{0, 1, 2, 3, 0};
  localparam int           RV     [NI] = '{0, 0, 0, 0, 1};
  localparam int           DLY    [NI] = '{1, 0, 2, 3, 3};
  localparam logic [7:0]   INIT_V [NI] = '{8'hA5, 8'h3C, 8'hA5, 8'h0F, 8'hA5};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] S, R;   // logical requests, 1 = asserted
  logic       clr;
  wire  [NI*40-1:0] act;   // per instance {q,nq,both,race,sticky}

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    sr_latch_bank_if #(.N(8)) bus ();
    assign bus.s          = (AL[k] != 0) ? ~S : S;
    assign bus.r          = (AL[k] != 0) ? ~R : R;
    assign bus.clr_sticky = clr;
    sr_latch_bank #(
      .N(8), .ACTIVE_LOW(AL[k]), .INIT(INIT_V[k]), .BOTH_MODE(MODE[k]),
      .RACE_VAL(RV[k]), .DELAY(DLY[k])
    ) u_dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus.slave)
    );
    assign act[k*40 +: 40] = {bus.q, bus.nq, bus.both_flag, bus.race_pulse, bus.illegal_sticky};
  end

  // ---------------- reference model ----------------
  // st: 0 = q low, 1 = q high, 2 = both outputs high.
  int           st   [NI][8];
  bit           rc   [NI][8];
  bit           stk  [NI][8];
  logic [31:0]  hist [NI][5];   // hist[k][d] = visible outputs d edges ago
  logic [NI*40-1:0] expv;

  task automatic model_edge();
    logic [7:0] qv, nqv, bv, rvv, sv;
    for (int k = 0; k < NI; k++) begin
      for (int d = 4; d > 0; d--) hist[k][d] = hist[k][d-1];
      for (int c = 0; c < 8; c++) begin
        if (rst) begin
          st[k][c]  = INIT_V[k][c] ? 1 : 0;
          rc[k][c]  = 0;
          stk[k][c] = 0;
        end else begin
          rc[k][c] = 0;
          if (S[c] && R[c]) begin
            stk[k][c] = 1;
            if (MODE[k] == 0)      st[k][c] = 2;
            else if (MODE[k] == 1) st[k][c] = 1;
            else if (MODE[k] == 2) st[k][c] = 0;
          end else begin
            if (S[c])                st[k][c] = 1;
            else if (R[c])           st[k][c] = 0;
            else if (st[k][c] == 2) begin st[k][c] = RV[k]; rc[k][c] = 1; end
            if (clr) stk[k][c] = 0;
          end
        end
        qv[c]  = (st[k][c] != 0);
        nqv[c] = (st[k][c] != 1);
        bv[c]  = (st[k][c] == 2);
        rvv[c] = rc[k][c];
        sv[c]  = stk[k][c];
      end
      hist[k][0] = {qv, nqv, bv, rvv};
      if (rst) for (int d = 1; d < 5; d++) hist[k][d] = hist[k][0];
      expv[k*40 +: 40] = {hist[k][DLY[k]], sv};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; clr = 1;
    for (int i = 0; i < 2; i++) begin
      S = 8'($urandom); R = 8'($urandom);
      tick();
      checks++;
      if (act !== expv) begin errors++; $display("FAIL reset_hold act=%h exp=%h", act, expv); end
    end
    checks++;
    if (act[39:0] !== 40'hA5_5A_00_00_00) begin
      errors++; $display("FAIL reset_u0 act=%h exp=a55a000000", act[39:0]);
    end
    rst = 0; clr = 0; S = 0; R = 0;
    tick();
    checks++;
    if (act[39:0] !== 40'hA5_5A_00_00_00) begin
      errors++; $display("FAIL reset_release_u0 act=%h exp=a55a000000", act[39:0]);
    end
    checks++;
    if (act !== expv) begin errors++; $display("FAIL reset_release act=%h exp=%h", act, expv); end
  endtask

  task automatic test_set_reset();
    S = 8'h00; R = 8'h01;
    tick();
    checks++;
    if (act[32] !== 1'b1) begin errors++; $display("FAIL sr_lat1 q0=%b exp=1", act[32]); end
    tick();
    checks++;
    if (act[32] !== 1'b0) begin errors++; $display("FAIL sr_reset q0=%b exp=0", act[32]); end
    S = 8'h01; R = 8'h00;
    tick();
    checks++;
    if (act[32] !== 1'b0) begin errors++; $display("FAIL sr_lat2 q0=%b exp=0", act[32]); end
    tick();
    checks++;
    if (act[32] !== 1'b1) begin errors++; $display("FAIL sr_set q0=%b exp=1", act[32]); end
    checks++;
    if (act !== expv) begin errors++; $display("FAIL sr_all act=%h exp=%h", act, expv); end
  endtask

  task automatic test_both_race();
    S = 8'h08; R = 8'h08;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (act !== expv) begin errors++; $display("FAIL both_hold cyc=%0d act=%h exp=%h", i, act, expv); end
    end
    checks++;
    if ({act[35], act[27], act[19], act[3]} !== 4'b1111) begin
      errors++; $display("FAIL both_u0 q/nq/both/sticky=%b exp=1111", {act[35], act[27], act[19], act[3]});
    end
    S = 0; R = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (act !== expv) begin errors++; $display("FAIL race_rel cyc=%0d act=%h exp=%h", i, act, expv); end
      if (i == 1) begin
        checks++;
        if ({act[35], act[27], act[11]} !== 3'b011) begin
          errors++; $display("FAIL race_u0 q/nq/race=%b exp=011", {act[35], act[27], act[11]});
        end
      end
      if (i == 2) begin
        checks++;
        if (act[11] !== 1'b0) begin errors++; $display("FAIL race_once race=%b exp=0", act[11]); end
      end
    end
  endtask

  task automatic test_release_one();
    S = 8'h08; R = 8'h08;
    tick(); tick();
    S = 8'h00; R = 8'h08;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (act !== expv) begin errors++; $display("FAIL rel_one cyc=%0d act=%h exp=%h", i, act, expv); end
      if (act[11] !== 1'b0 || act[171] !== 1'b0) begin
        errors++; $display("FAIL rel_one_race u0=%b u4=%b exp=0", act[11], act[171]);
      end
    end
    checks++;
    if ({act[35], act[27]} !== 2'b01) begin
      errors++; $display("FAIL rel_one_q q/nq=%b exp=01", {act[35], act[27]});
    end
  endtask

  task automatic test_modes();
    clr = 0;
    for (int pass = 0; pass < 2; pass++) begin
      S = (pass == 0) ? 8'h00 : 8'hFF;
      R = (pass == 0) ? 8'hFF : 8'h00;
      for (int i = 0; i < 4; i++) tick();
      S = 8'hFF; R = 8'hFF;
      for (int i = 0; i < 4; i++) begin
        tick();
        checks++;
        if (act !== expv) begin errors++; $display("FAIL modes p=%0d cyc=%0d act=%h exp=%h", pass, i, act, expv); end
      end
      checks++;
      if ({act[79:72], act[119:112], act[159:152]} !== {8'hFF, 8'h00, (pass == 0) ? 8'h00 : 8'hFF}) begin
        errors++; $display("FAIL modes_q p=%0d m1/m2/m3=%h", pass, {act[79:72], act[119:112], act[159:152]});
      end
    end
    clr = 1;
    tick();
    checks++;
    if (act[47:40] !== 8'hFF) begin errors++; $display("FAIL sticky_setwins act=%h exp=ff", act[47:40]); end
    S = 0; R = 0;
    tick();
    checks++;
    if (act[47:40] !== 8'h00) begin errors++; $display("FAIL sticky_clr act=%h exp=00", act[47:40]); end
    checks++;
    if (act !== expv) begin errors++; $display("FAIL modes_clr act=%h exp=%h", act, expv); end
    clr = 0;
  endtask

  task automatic test_delay_reset();
    logic drv [$];
    for (int i = 0; i < 10; i++) begin
      S = (i % 2 == 1) ? 8'h80 : 8'h00;
      R = (i % 2 == 1) ? 8'h00 : 8'h80;
      drv.push_back(i % 2 == 1);
      tick();
      checks++;
      if (act !== expv) begin errors++; $display("FAIL dly cyc=%0d act=%h exp=%h", i, act, expv); end
      if (i >= 3) begin
        checks++;
        if (act[159] !== drv[i-3]) begin errors++; $display("FAIL dly_lag cyc=%0d q7=%b exp=%b", i, act[159], drv[i-3]); end
      end
    end
    rst = 1;
    S = 8'h00; R = 8'h80;
    tick();
    checks++;
    if ({act[159:152], act[135:128], act[199:192]} !== {8'h0F, 8'h00, 8'hA5}) begin
      errors++; $display("FAIL dly_reset u3q/u3race/u4q=%h exp=0f00a5", {act[159:152], act[135:128], act[199:192]});
    end
    rst = 0; S = 0; R = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (act !== expv) begin errors++; $display("FAIL dly_post cyc=%0d act=%h exp=%h", i, act, expv); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 40) == 0);
      clr = ($urandom_range(0, 7) == 0);
      S   = 8'($urandom);
      R   = 8'($urandom) & (($urandom_range(0, 2) == 0) ? 8'hFF : ~S);
      tick();
      checks++;
      if (act !== expv) begin errors++; $display("FAIL random cyc=%0d act=%h exp=%h", i, act, expv); end
    end
    rst = 0; clr = 0;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      for (int d = 0; d < 5; d++) hist[k][d] = '0;
      for (int c = 0; c < 8; c++) begin st[k][c] = 0; rc[k][c] = 0; stk[k][c] = 0; end
    end
    expv = '0;
    rst = 1; S = 0; R = 0; clr = 0;
    test_reset();
    test_set_reset();
    test_both_race();
    test_release_one();
    test_modes();
    test_delay_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
